// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory read by the fetch stage. A byte stream
// arrives over a valid/ready handshake. The loader packs it MSB-first into
// 32-bit words and writes them to word addresses 0..N-1. A trailing 4-byte
// XOR checksum is compared against the XOR of all written words. The CPU is
// held in reset until a load completes with a matching checksum.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       one-cycle pulse, begins a load (honoured in IDLE or DONE only)
//   word_count  program length in words, legal 1..2^ADDR_W, sampled with start
//   byte_i      stream byte
//   byte_valid  byte_i is valid
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction memory write strobe, one cycle per word
//   mem_addr    word address for the write
//   mem_wdata   word to write
//   cpu_hold    CPU reset; high holds the fetch PC at 0
//   busy        load in progress
//   done        load finished (success or failure), level
//   err         bad word_count or checksum mismatch, level
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Largest legal word_count: one word per memory entry.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic [1:0]          byte_cnt;   // bytes received in the current word
  logic [ADDR_W-1:0]   word_idx;   // address of the word being assembled
  logic [ADDR_W-1:0]   last_idx;   // word_count - 1, latched at start
  logic [DATA_W-1:0]   shift;      // MSB-first assembly register
  logic [DATA_W-1:0]   acc;        // XOR of all words written so far
  logic [DATA_W-1:0]   next_word;  // assembly register including this byte
  logic                xfer;
  logic                count_ok;

  assign next_word = {shift[DATA_W-9:0], byte_i};
  // byte_ready is registered and high only in LOAD/CSUM, so it alone gates
  // the handshake; bytes offered in any other state are left for the source.
  assign xfer      = byte_valid && byte_ready;
  assign count_ok  = (word_count != '0) && (word_count <= DEPTH);

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples pre-edge values, exactly like the flops it models.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      shift      <= '0;
      acc        <= '0;
    end else begin
      // Write strobe is a single-cycle pulse; only LOAD re-arms it.
      mem_we <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (count_ok) begin
              last_idx   <= ADDR_W'(word_count - 1'b1);
              acc        <= '0;
              shift      <= '0;
              byte_cnt   <= '0;
              word_idx   <= '0;
              done       <= 1'b0;
              err        <= 1'b0;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= LOAD;
            end else begin
              // Rejected length: report failure, keep the CPU held, stay put.
              err      <= 1'b1;
              done     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            shift    <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Present the finished word during the WRITE cycle.
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_wdata  <= next_word;
              mem_addr   <= word_idx;
              state      <= WRITE;
            end
          end
        end

        WRITE: begin
          acc        <= acc ^ mem_wdata;
          word_idx   <= word_idx + ADDR_W'(1);
          byte_ready <= 1'b1;
          // word_count <= DEPTH, so last_idx is reached before word_idx wraps.
          state      <= (word_idx == last_idx) ? CSUM : LOAD;
        end

        CSUM: begin
          if (xfer) begin
            shift    <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              err        <= (next_word != acc);
              cpu_hold   <= (next_word != acc);
              state      <= DONE;
            end
          end
        end

        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A table of load scenarios (length,
// checksum, handshake gaps, expected error) is applied in a loop; full-depth
// and asynchronous-reset cases are hand-written sequences. A monitor records
// every memory write for comparison against the expected image.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  byte_i;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_i     (byte_i),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write monitor, sampled mid-cycle.
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_viol = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (byte_ready) ready_viol++;
    end
  end

  typedef struct {
    string       name;
    logic [8:0]  wc;
    logic [31:0] csum;
    bit          gaps;
    bit          exp_err;
  } vec_t;

  // Two-word test image, MSB first.
  logic [7:0]  img_bytes[8] = '{8'h00, 8'h00, 8'h00, 8'h11,
                                8'h22, 8'h33, 8'h44, 8'h55};
  logic [31:0] img_words[2] = '{32'h0000_0011, 32'h2233_4455};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_viol = 0;
  endtask

  // Offer one byte from a negedge and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    bit taken = 0;
    byte_i     = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50 && !taken; t++) begin
      if (byte_ready) taken = 1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!taken) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte timeout: byte 0x%02h never accepted", b);
    end
  endtask

  task automatic idle_cycles(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 50 && !done; t++) @(negedge clk);
    check({name, " done"}, {31'b0, done}, 32'd1);
  endtask

  // Legal two-word load of img_bytes followed by the given checksum.
  task automatic run_load(input vec_t v);
    clear_log();
    pulse_start(v.wc);
    check({v.name, " hold after start"}, {31'b0, cpu_hold}, 32'd1);
    check({v.name, " busy after start"}, {31'b0, busy}, 32'd1);
    check({v.name, " done cleared"},     {31'b0, done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(img_bytes[i]);
      if (v.gaps) begin
        idle_cycles(2);
        // start in LOAD must be ignored, even with an illegal length
        if (i == 1) pulse_start(9'd0);
      end
    end
    send_word(v.csum);
    wait_done(v.name);
    check({v.name, " write count"}, wr_addr.size(), 32'd2);
    for (int k = 0; k < 2 && k < wr_addr.size(); k++) begin
      check($sformatf("%s addr%0d", v.name, k), {24'b0, wr_addr[k]}, k);
      check($sformatf("%s data%0d", v.name, k), wr_data[k], img_words[k]);
    end
    check({v.name, " ready low in WRITE"}, ready_viol, 32'd0);
    check({v.name, " err"},      {31'b0, err},      {31'b0, v.exp_err});
    check({v.name, " cpu_hold"}, {31'b0, cpu_hold}, {31'b0, v.exp_err});
    check({v.name, " busy"},     {31'b0, busy},     32'd0);
    check({v.name, " byte_ready"}, {31'b0, byte_ready}, 32'd0);
  endtask

  task automatic run_illegal(input vec_t v);
    clear_log();
    pulse_start(v.wc);
    repeat (3) @(negedge clk);
    check({v.name, " err"},      {31'b0, err},      32'd1);
    check({v.name, " done"},     {31'b0, done},     32'd1);
    check({v.name, " cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    check({v.name, " busy"},     {31'b0, busy},     32'd0);
    check({v.name, " no writes"}, wr_addr.size(),   32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " byte_ready"}, {31'b0, byte_ready}, 32'd0);
    check({name, " mem_we"},     {31'b0, mem_we},     32'd0);
    check({name, " mem_addr"},   {24'b0, mem_addr},   32'd0);
    check({name, " mem_wdata"},  mem_wdata,           32'd0);
    check({name, " cpu_hold"},   {31'b0, cpu_hold},   32'd1);
    check({name, " busy"},       {31'b0, busy},       32'd0);
    check({name, " done"},       {31'b0, done},       32'd0);
    check({name, " err"},        {31'b0, err},        32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"good2",   9'd2,   32'h2233_4444, 1'b0, 1'b0};
    vecs[1] = '{"badcsum", 9'd2,   32'h0000_0000, 1'b0, 1'b1};
    vecs[2] = '{"gaps",    9'd2,   32'h2233_4444, 1'b1, 1'b0};
    vecs[3] = '{"len0",    9'd0,   32'h0,         1'b0, 1'b1};
    vecs[4] = '{"len257",  9'd257, 32'h0,         1'b0, 1'b1};
    vecs[5] = '{"relegal", 9'd2,   32'h2233_4444, 1'b0, 1'b0};

    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_i     = '0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wc != 0 && vecs[i].wc <= 9'd256) run_load(vecs[i]);
      else                                         run_illegal(vecs[i]);
    end

    // Full depth: 256 words, word k = k; XOR of 0..255 is 0.
    clear_log();
    pulse_start(9'd256);
    for (int k = 0; k < 256; k++) send_word(32'(k));
    send_word(32'h0000_0000);
    wait_done("full");
    check("full write count", wr_addr.size(), 32'd256);
    if (wr_addr.size() == 256) begin
      check("full last addr", {24'b0, wr_addr[255]}, 32'd255);
      check("full last data", wr_data[255], 32'h0000_00FF);
      check("full addr100",   {24'b0, wr_addr[100]}, 32'd100);
      check("full data100",   wr_data[100], 32'd100);
    end
    check("full err",      {31'b0, err},      32'd0);
    check("full cpu_hold", {31'b0, cpu_hold}, 32'd0);

    // Async reset mid-word, between clock edges.
    clear_log();
    pulse_start(9'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    run_load(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit words, most significant byte first.
- Writes the words to word addresses 0..N-1 of the 256-entry instruction memory.
- Holds the CPU in reset until the image is loaded and its XOR checksum verifies, so fetch starts at PC 0 with a valid program.

Parameters:
- ADDR_W, 8, instruction memory word-address width (depth 2^ADDR_W = 256)
- DATA_W, 32, instruction word width; fixed at 4 bytes

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- word_count  input  9  number of program words, legal range 1..256; sampled with start
- byte_i  input  8  stream byte
- byte_valid  input  1  byte_i is valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  8  word address for the write
- mem_wdata  output  32  word to write
- cpu_hold  output  1  drive to the CPU rst; high holds the fetch PC at 0
- busy  output  1  load in progress
- done  output  1  load finished, success or failure; level signal
- err  output  1  failure: bad word_count or checksum mismatch; level signal

Behaviour:
- Reset (async, any state): state=IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1. Internal byte counter, word counter and XOR accumulator are cleared.
- States: IDLE, LOAD, WRITE, CSUM, DONE.
- IDLE/DONE on start:
  - word_count in 1..256: latch word_count; clear the accumulator, counters, done and err; set cpu_hold=1 and busy=1; go to LOAD.
  - word_count 0 or >256: set err=1 and done=1; cpu_hold stays 1; state unchanged; no writes.
- start is ignored in LOAD, WRITE and CSUM.
- LOAD:
  - byte_ready=1.
  - A byte transfers on the rising edge where byte_valid && byte_ready. It shifts into the assembly register: word = {word[23:0], byte_i}.
  - After the 4th byte, go to WRITE. byte_valid gaps are allowed; state holds until a byte arrives.
- WRITE (exactly one cycle):
  - byte_ready=0; mem_we=1; mem_wdata = assembled word; mem_addr = current word index.
  - The accumulator XORs in the word.
  - Word index increments. If this was word word_count-1, go to CSUM; otherwise go to LOAD.
  - Minimum rate: 5 cycles per word.
- mem_addr is registered and valid whenever mem_we=1. Index 255 is the last legal address and never wraps, because word_count ≤ 256.
- CSUM:
  - byte_ready=1; accept 4 bytes MSB-first as the expected checksum; no memory write.
  - After the 4th byte, compare with the accumulator and go to DONE.
    - Match: err=0, cpu_hold=0.
    - Mismatch: err=1, cpu_hold stays 1.
- DONE: done=1, busy=0, byte_ready=0; outputs hold until start or rst.
- A start from DONE restarts the load: cpu_hold goes back to 1 on the cycle after start.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them.
- Reset mid-load abandons the image. Memory words already written stay as they are; this block has no memory-clear function.

Test Plan:
- 2-word load:
  - Stimulus: start with word_count=2; bytes 00 00 00 11, 22 33 44 55, checksum 22 33 44 44.
  - Required: writes addr0=0x00000011 and addr1=0x22334455, one mem_we cycle each; then done=1, err=0, cpu_hold=0, busy=0.
- Bad checksum:
  - Stimulus: same image with checksum 00 00 00 00.
  - Required: both writes occur; done=1, err=1, cpu_hold=1.
- Handshake gaps:
  - Stimulus: byte_valid toggled 1,0,0,1 and held off during WRITE cycles.
  - Required: each byte consumed once; word values identical to the 2-word load; byte_ready=0 in every WRITE cycle.
- Illegal length:
  - Stimulus: start with word_count=0, then separately word_count=257.
  - Required: err=1, done=1, no mem_we, cpu_hold=1; a later legal start clears err.
- Full depth:
  - Stimulus: word_count=256, word k = k.
  - Required: last write at addr 255 with data 0x000000FF; correct checksum 0x00000000 gives err=0.
- Async reset:
  - Stimulus: rst asserted mid-word in LOAD, between clock edges.
  - Required: outputs immediately at reset values, cpu_hold=1; a new start reloads from addr 0.
